// File: rtl/mantissa_mult_core.sv
// Sequential shift-and-add unsigned multiplier: one partial product per int_clk
// cycle, WIDTH cycles per operation, registered product with a one-cycle done pulse.
module mantissa_mult_core #(
  parameter int WIDTH = 4
) (
  input  logic                 int_clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_reg;
  logic [2*WIDTH-1:0]   mcand_reg;
  logic [2*WIDTH-1:0]   acc_reg;
  logic [WIDTH-1:0]     mplr_reg;
  logic [CW-1:0]        count_reg;
  logic [2*WIDTH-1:0]   addend;

  // Partial product selected by the current low multiplier bit.
  assign addend = mplr_reg[0] ? mcand_reg : '0;

  always_ff @(posedge int_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      mcand_reg <= '0;
      acc_reg   <= '0;
      mplr_reg  <= '0;
      count_reg <= '0;
      product   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            mcand_reg <= {{WIDTH{1'b0}}, a};
            mplr_reg  <= b;
            acc_reg   <= '0;
            count_reg <= '0;
            busy      <= 1'b1;
            state_reg <= RUN;
          end
        end
        RUN: begin
          acc_reg   <= acc_reg + addend;
          mcand_reg <= mcand_reg << 1;
          mplr_reg  <= mplr_reg >> 1;
          count_reg <= count_reg + 1'b1;
          if (count_reg == LAST) begin
            // Fold the last partial product straight into the result register.
            product   <= acc_reg + addend;
            busy      <= 1'b0;
            done      <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          done <= 1'b0;
          if (start) begin
            mcand_reg <= {{WIDTH{1'b0}}, a};
            mplr_reg  <= b;
            acc_reg   <= '0;
            count_reg <= '0;
            busy      <= 1'b1;
            state_reg <= RUN;
          end else begin
            busy      <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: begin
          busy      <= 1'b0;
          done      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mantissa_mult_core.sv
// Bench for mantissa_mult_core: cycle-level reference model checked every cycle,
// plus directed operations with hand-computed products and latencies.
module tb_mantissa_mult_core;

  localparam int W = 4;

  logic             int_clk;
  logic             rst_n;
  logic             start;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic [2*W-1:0]   product;
  logic             busy;
  logic             done;

  int n_cmp  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  mantissa_mult_core #(.WIDTH(W)) dut (
    .int_clk (int_clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .product (product),
    .busy    (busy),
    .done    (done)
  );

  initial begin
    int_clk = 1'b0;
    forever #5 int_clk = ~int_clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted request keeps the unit busy for W cycles,
  // then shows a*b with done for one cycle, during which a new start is taken.
  int             m_run_left;
  bit             m_done;
  logic [2*W-1:0] m_pend;
  logic [2*W-1:0] m_prod;

  always @(posedge int_clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run_left <= 0;
      m_done     <= 1'b0;
      m_pend     <= '0;
      m_prod     <= '0;
    end else if (m_run_left > 0) begin
      m_run_left <= m_run_left - 1;
      m_done     <= (m_run_left == 1);
      if (m_run_left == 1) m_prod <= m_pend;
    end else begin
      m_done <= 1'b0;
      if (start) begin
        m_run_left <= W;
        m_pend     <= {{W{1'b0}}, a} * {{W{1'b0}}, b};
      end
    end
  end

  always @(negedge int_clk) begin
    if (cmp_en) begin
      check("model_busy", 64'(busy), 64'(m_run_left > 0));
      check("model_done", 64'(done), 64'(m_done));
      check("model_product", 64'(product), 64'(m_prod));
      check("busy_done_exclusive", 64'(busy & done), 64'd0);
    end
  end

  // Pulse start for one edge, then count edges from acceptance to done.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [2*W-1:0] exp_p, input string name);
    int n;
    bit seen;
    @(posedge int_clk); #1;
    start = 1'b1; a = av; b = bv;
    @(posedge int_clk); #1;
    start = 1'b0;
    check({name, "_busy_after_accept"}, 64'(busy), 64'd1);
    n = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge int_clk); #1;
      n++;
      if (done) seen = 1'b1;
    end
    check({name, "_latency"}, 64'(n), 64'(W));
    check({name, "_product"}, 64'(product), 64'(exp_p));
    $display("op %s: a=%0d b=%0d product=%0d latency=%0d", name, av, bv, product, n);
    @(posedge int_clk); #1;
    check({name, "_done_low"}, 64'(done), 64'd0);
  endtask

  initial begin
    int n;
    bit seen;
    start = 1'b0; a = '0; b = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 cmp_en = 1'b1;
    check("reset_product", 64'(product), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    repeat (2) @(negedge int_clk);
    #2 rst_n = 1'b1;

    run_op(4'd3,  4'd5,  8'h0F, "3x5");
    run_op(4'd15, 4'd15, 8'hE1, "15x15");
    run_op(4'd0,  4'd9,  8'd0,  "0x9");
    run_op(4'd9,  4'd0,  8'd0,  "9x0");

    // Back-to-back: a start held during the DONE cycle is accepted.
    @(posedge int_clk); #1;
    start = 1'b1; a = 4'd7; b = 4'd6;
    @(posedge int_clk); #1;
    start = 1'b0;
    n = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge int_clk); #1; n++;
      if (done) seen = 1'b1;
    end
    check("7x6_product", 64'(product), 64'd42);
    $display("op 7x6: product=%0d latency=%0d", product, n);
    start = 1'b1; a = 4'd9; b = 4'd11;
    n = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge int_clk); #1; n++;
      start = 1'b0;
      if (done) seen = 1'b1;
    end
    check("b2b_gap", 64'(n), 64'(W + 1));
    check("9x11_product", 64'(product), 64'd99);
    $display("op 9x11 back-to-back: product=%0d cycles_since_prev_done=%0d", product, n);
    @(posedge int_clk); #1;

    // Start pulses and operand churn during RUN must not disturb 3x5.
    start = 1'b1; a = 4'd3; b = 4'd5;
    @(posedge int_clk); #1;
    start = 1'b0;
    @(posedge int_clk); #1;
    start = 1'b1; a = 4'd15; b = 4'd15;
    @(posedge int_clk); #1;
    a = 4'd0; b = 4'd7;
    @(posedge int_clk); #1;
    start = 1'b0; a = 4'd5; b = 4'd9;
    n = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge int_clk); #1; n++;
      if (done) seen = 1'b1;
    end
    check("ignore_start_latency", 64'(n), 64'd1);
    check("ignore_start_product", 64'(product), 64'd15);
    $display("op 3x5 with run-time start noise: product=%0d", product);
    @(posedge int_clk); #1;

    // Asynchronous reset in the middle of a 13x11 run.
    start = 1'b1; a = 4'd13; b = 4'd11;
    @(posedge int_clk); #1;
    start = 1'b0;
    repeat (2) @(posedge int_clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_product", 64'(product), 64'd0);
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_done", 64'(done), 64'd0);
    $display("op 13x11 aborted by reset: product=%0d busy=%0d done=%0d", product, busy, done);
    @(negedge int_clk); #2 rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge int_clk); #1;
      if (done) seen = 1'b1;
    end
    check("no_done_after_abort", 64'(seen), 64'd0);
    check("product_zero_after_abort", 64'(product), 64'd0);
    run_op(4'd2, 4'd3, 8'd6, "2x3");

    repeat (2) @(posedge int_clk);
    #1 cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL global_timeout: got time %0t, expected completion earlier", $time);
    $fatal(1, "timeout");
  end

endmodule
